// File: rtl/gpio_input_irq_pio_if.sv
// Avalon-MM slave bus bundle for gpio_input_irq_pio.
// Latency: n/a (wiring only).
// Backpressure: none; the bus has no waitrequest.
//
// Signals:
//   address    - register select (0 DATA, 1 MASK, 2 EDGE, 3 POL)
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - write data
//   readdata   - registered read data, driven by the slave
interface gpio_input_irq_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/gpio_input_irq_pio.sv
// Parametrised Avalon-MM input PIO with synchroniser, edge capture and level irq.
// Latency: readdata 1 cycle after address; in_port change reaches DATA/EDGE 2 edges
//          after sampling (plus DEBOUNCE_CYCLES when GPIO_INPUT_IRQ_PIO_DEBOUNCE_EN is defined).
// Backpressure: none; every read and write completes in one cycle.
//
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset
//   bus          - Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port      - WIDTH asynchronous external inputs
//   irq          - level interrupt, OR of (EDGE & MASK)
// Optional feature macro: GPIO_INPUT_IRQ_PIO_DEBOUNCE_EN enables the per-bit debouncer.
module gpio_input_irq_pio #(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  gpio_input_irq_pio_if.slave   bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_POL  = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] pol_q, pol_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] wdat;
  logic             wr_en;

  // Upper writedata bits are ignored by design; DEBOUNCE_CYCLES is only
  // consumed by the debouncer build.
  logic unused_ok;
  assign unused_ok = ^{bus.writedata, 16'(DEBOUNCE_CYCLES)};

`ifdef GPIO_INPUT_IRQ_PIO_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // filt flips on the DEBOUNCE_CYCLES-th consecutive differing cycle, so the
  // accepted value lands exactly DEBOUNCE_CYCLES cycles after sync2 changed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  always_comb begin
    wr_en   = bus.chipselect & ~bus.write_n;
    wdat    = bus.writedata[WIDTH-1:0];
    sync1_d = in_port;
    sync2_d = sync1_q;
    prev_d  = filt;

    // Per-bit polarity picks which transition of filt counts as an event.
    edge_evt = (~pol_q & filt & ~prev_q) | (pol_q & ~filt & prev_q);

    mask_d   = mask_q;
    pol_d    = pol_q;
    edge_clr = '0;
    if (wr_en) begin
      case (bus.address)
        ADDR_MASK: mask_d   = wdat;
        ADDR_EDGE: edge_clr = wdat;
        ADDR_POL:  pol_d    = wdat;
        default:   ;
      endcase
    end

    // Clear first, then OR the new events so a same-cycle set survives W1C.
    edge_d = (edge_q & ~edge_clr) | edge_evt;

    readdata_d = '0;
    case (bus.address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = filt;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
      ADDR_POL:  readdata_d[WIDTH-1:0] = pol_q;
      default:   readdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      pol_q      <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      pol_q      <= pol_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edge_q & mask_q);

endmodule

// File: tb/tb_gpio_input_irq_pio.sv
// Testbench for gpio_input_irq_pio: directed vector table, debounce pulse
// sequences, randomized traffic against a history-based reference model.
module tb_gpio_input_irq_pio;

  localparam int DB_CYC = 16;
`ifdef GPIO_INPUT_IRQ_PIO_DEBOUNCE_EN
  localparam int DB = DB_CYC;
`else
  localparam int DB = 0;
`endif
  // Edges from sampling an input change to it being seen as filt's value.
  localparam int LAT = 2 + DB;

  logic       clk;
  logic       reset_n;
  logic [5:0] in_port;
  logic       irq;

  gpio_input_irq_pio_if bus_if ();

  gpio_input_irq_pio #(
    .WIDTH           (6),
    .DEBOUNCE_CYCLES (DB_CYC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .in_port (in_port),
    .irq     (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the input history plus the three software registers.
  logic [5:0]  hist [$];
  logic [5:0]  m_mask, m_pol, m_edge;
  logic [31:0] m_rd;
  logic        m_irq;

  function automatic logic [5:0] hval(input int k);
    if (k < 0) return 6'd0;
    return hist[k];
  endfunction

  task automatic model_reset();
    hist.delete();
    m_mask = '0; m_pol = '0; m_edge = '0; m_rd = '0; m_irq = 1'b0;
  endtask

  task automatic model_update(input logic [1:0] a, input logic c, input logic wn,
                              input logic [31:0] d, input logic [5:0] i);
    logic [5:0] filt, prev, ev;
    int k;
    hist.push_back(i);
    k    = hist.size() - 1;
    filt = hval(k - LAT);
    prev = hval(k - LAT - 1);
    case (a)
      2'd0: m_rd = {26'd0, filt};
      2'd1: m_rd = {26'd0, m_mask};
      2'd2: m_rd = {26'd0, m_edge};
      default: m_rd = {26'd0, m_pol};
    endcase
    ev = 6'd0;
    for (int b = 0; b < 6; b++) begin
      if (m_pol[b] == 1'b0 && filt[b] && !prev[b]) ev[b] = 1'b1;
      if (m_pol[b] == 1'b1 && !filt[b] && prev[b]) ev[b] = 1'b1;
    end
    if (c && !wn) begin
      if (a == 2'd1) m_mask = d[5:0];
      if (a == 2'd2) m_edge = m_edge & ~d[5:0];
      if (a == 2'd3) m_pol  = d[5:0];
    end
    m_edge = m_edge | ev;
    m_irq  = (m_edge & m_mask) != 6'd0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive, let one posedge pass, return at next negedge.
  task automatic step(input logic [1:0] a, input logic c, input logic wn,
                      input logic [31:0] d, input logic [5:0] i);
    bus_if.address    = a;
    bus_if.chipselect = c;
    bus_if.write_n    = wn;
    bus_if.writedata  = d;
    in_port           = i;
    @(posedge clk);
    model_update(a, c, wn, d, i);
    @(negedge clk);
  endtask

  task automatic step_chk(input string nm, input logic [1:0] a, input logic c, input logic wn,
                          input logic [31:0] d, input logic [5:0] i);
    step(a, c, wn, d, i);
    chk({nm, "_rd"}, bus_if.readdata, m_rd);
    chk({nm, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    if (check) begin
      chk("async_rst_rd", bus_if.readdata, 32'd0);
      chk("async_rst_irq", {31'd0, irq}, 32'd0);
    end
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    in_port           = 6'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

`ifndef GPIO_INPUT_IRQ_PIO_DEBOUNCE_EN
  typedef struct {
    logic [1:0]  a;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [5:0]  inp;
    logic [31:0] rd;
    logic        irq;
  } vec_t;
  vec_t tbl [38];

  function automatic vec_t v(input logic [1:0] a, input logic cs, input logic wn,
                             input logic [31:0] wd, input logic [5:0] inp,
                             input logic [31:0] rd, input logic ir);
    vec_t r;
    r.a = a; r.cs = cs; r.wn = wn; r.wd = wd; r.inp = inp; r.rd = rd; r.irq = ir;
    return r;
  endfunction
`endif

  logic [5:0] cur_in;
  int         hold;

  task automatic rand_cycle();
    if (hold == 0) begin
      cur_in = 6'($urandom);
      hold   = (DB == 0) ? int'($urandom_range(1, 4)) : DB + 2 + int'($urandom_range(0, 5));
    end
    hold--;
    step_chk("rand", 2'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0),
             $urandom, cur_in);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n           = 1'b0;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'd0;
    in_port           = 6'd0;
    cur_in            = 6'd0;
    hold              = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

`ifndef GPIO_INPUT_IRQ_PIO_DEBOUNCE_EN
    //         a  cs  wn  wdata          in      rd      irq
    tbl[0]  = v(1, 0, 1, 32'h0,        6'h00, 32'h00, 0);
    tbl[1]  = v(2, 0, 1, 32'h0,        6'h00, 32'h00, 0);
    tbl[2]  = v(3, 0, 1, 32'h0,        6'h00, 32'h00, 0);
    tbl[3]  = v(0, 0, 1, 32'h0,        6'h2A, 32'h00, 0);
    tbl[4]  = v(0, 0, 1, 32'h0,        6'h2A, 32'h00, 0);
    tbl[5]  = v(0, 0, 1, 32'h0,        6'h2A, 32'h2A, 0);
    tbl[6]  = v(0, 1, 0, 32'hFFFFFFFF, 6'h2A, 32'h2A, 0);
    tbl[7]  = v(0, 0, 1, 32'h0,        6'h2A, 32'h2A, 0);
    tbl[8]  = v(2, 0, 1, 32'h0,        6'h2A, 32'h2A, 0);
    tbl[9]  = v(2, 1, 0, 32'h3F,       6'h2A, 32'h2A, 0);
    tbl[10] = v(2, 0, 1, 32'h0,        6'h2A, 32'h00, 0);
    tbl[11] = v(1, 1, 0, 32'h01,       6'h2A, 32'h00, 0);
    tbl[12] = v(1, 0, 1, 32'h0,        6'h2B, 32'h01, 0);
    tbl[13] = v(2, 0, 1, 32'h0,        6'h2B, 32'h00, 0);
    tbl[14] = v(2, 0, 1, 32'h0,        6'h2B, 32'h00, 1);
    tbl[15] = v(2, 0, 1, 32'h0,        6'h2B, 32'h01, 1);
    tbl[16] = v(2, 1, 0, 32'h01,       6'h2B, 32'h01, 0);
    tbl[17] = v(2, 0, 1, 32'h0,        6'h2B, 32'h00, 0);
    tbl[18] = v(1, 1, 0, 32'h00,       6'h2B, 32'h01, 0);
    tbl[19] = v(3, 1, 0, 32'h04,       6'h2B, 32'h00, 0);
    tbl[20] = v(3, 0, 1, 32'h0,        6'h2F, 32'h04, 0);
    tbl[21] = v(2, 0, 1, 32'h0,        6'h2F, 32'h00, 0);
    tbl[22] = v(2, 0, 1, 32'h0,        6'h2F, 32'h00, 0);
    tbl[23] = v(2, 0, 1, 32'h0,        6'h2B, 32'h00, 0);
    tbl[24] = v(2, 0, 1, 32'h0,        6'h2B, 32'h00, 0);
    tbl[25] = v(2, 0, 1, 32'h0,        6'h2B, 32'h00, 0);
    tbl[26] = v(2, 0, 1, 32'h0,        6'h2B, 32'h04, 0);
    tbl[27] = v(1, 1, 0, 32'h04,       6'h2B, 32'h00, 1);
    tbl[28] = v(1, 0, 1, 32'h0,        6'h2B, 32'h04, 1);
    tbl[29] = v(2, 1, 0, 32'h04,       6'h2B, 32'h04, 0);
    tbl[30] = v(2, 0, 1, 32'h0,        6'h2A, 32'h00, 0);
    tbl[31] = v(2, 0, 1, 32'h0,        6'h2A, 32'h00, 0);
    tbl[32] = v(2, 0, 1, 32'h0,        6'h2A, 32'h00, 0);
    tbl[33] = v(2, 0, 1, 32'h0,        6'h2B, 32'h00, 0);
    tbl[34] = v(2, 0, 1, 32'h0,        6'h2B, 32'h00, 0);
    tbl[35] = v(2, 1, 0, 32'h01,       6'h2B, 32'h00, 0);
    tbl[36] = v(2, 0, 1, 32'h0,        6'h2B, 32'h01, 0);
    tbl[37] = v(0, 0, 1, 32'h0,        6'h2B, 32'h2B, 0);
    for (int r = 0; r < 38; r++) begin
      step(tbl[r].a, tbl[r].cs, tbl[r].wn, tbl[r].wd, tbl[r].inp);
      chk($sformatf("vec%0d_rd", r), bus_if.readdata, tbl[r].rd);
      chk($sformatf("vec%0d_irq", r), {31'd0, irq}, {31'd0, tbl[r].irq});
    end
`else
    // Short glitch must never reach DATA or EDGE.
    step(2'd1, 1'b1, 1'b0, 32'h2, 6'h00);
    for (int j = 0; j < 10; j++) step(2'd0, 1'b0, 1'b1, 32'h0, 6'h02);
    for (int j = 0; j < 30; j++) step(2'd0, 1'b0, 1'b1, 32'h0, 6'h00);
    chk("db_short_data", bus_if.readdata, 32'h0);
    step(2'd2, 1'b0, 1'b1, 32'h0, 6'h00);
    chk("db_short_edge", bus_if.readdata, 32'h0);
    chk("db_short_irq", {31'd0, irq}, 32'd0);
    // Long pulse is accepted 2+DEBOUNCE_CYCLES edges after sampling.
    for (int j = 0; j < 40; j++) begin
      step(2'd0, 1'b0, 1'b1, 32'h0, (j < 20) ? 6'h02 : 6'h00);
      if (j == 17) begin
        chk("db_long_data_early", bus_if.readdata, 32'h0);
        chk("db_long_irq_early", {31'd0, irq}, 32'd0);
      end
      if (j == 18) begin
        chk("db_long_data", bus_if.readdata, 32'h2);
        chk("db_long_irq", {31'd0, irq}, 32'd1);
      end
    end
    step(2'd2, 1'b0, 1'b1, 32'h0, 6'h00);
    chk("db_long_edge", bus_if.readdata, 32'h2);
`endif

    do_reset(1'b0);

    for (int n = 0; n < 1500; n++) rand_cycle();
    while (hold != 0) rand_cycle();

    // Build a pending irq, then reset mid-operation and see it vanish.
    step_chk("pre_pol", 2'd3, 1'b1, 1'b0, 32'h0, cur_in);
    step_chk("pre_mask", 2'd1, 1'b1, 1'b0, 32'h3F, cur_in);
    for (int j = 0; j < LAT + 3; j++) step_chk("pre_low", 2'd2, 1'b0, 1'b1, 32'h0, 6'h00);
    for (int j = 0; j < LAT + 3; j++) step_chk("pre_high", 2'd2, 1'b0, 1'b1, 32'h0, 6'h3F);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    do_reset(1'b1);
    step_chk("post_rst_mask", 2'd1, 1'b0, 1'b1, 32'h0, 6'h00);
    step_chk("post_rst_edge", 2'd2, 1'b0, 1'b1, 32'h0, 6'h00);
    step_chk("post_rst_pol", 2'd3, 1'b0, 1'b1, 32'h0, 6'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
